// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial add/subtract controller:
// FSM state encoding and the supported operand width range.
`timescale 1ns/1ps
package serial_add_ctrl_pkg;

   // Controller states, 2-bit encoding.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Supported operand/result width range.
   localparam int WIDTH_MIN = 2;
   localparam int WIDTH_MAX = 32;

   // Width of the bit counter for a given operand width.
   function automatic int cnt_width(input int width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/serial_add_ctrl_fa_cell.sv
// Single-bit full adder. It is the only arithmetic in the serial datapath,
// so the critical path between registers is one full-adder stage.
`timescale 1ns/1ps
module fa_cell (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   // Sum and carry of one bit position.
   always_comb begin
      s  = a ^ b ^ ci;
      co = (a & b) | (a & ci) | (b & ci);
   end

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract controller. Operands are captured on an accepted
// start, processed LSB first through one full-adder cell with a registered
// carry, and the result word is published on the RUN->DONE edge, where it
// holds until the next result.
`timescale 1ns/1ps
module serial_add_ctrl
   import serial_add_ctrl_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int CW = cnt_width(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] sha_q, sha_d;
   logic [WIDTH-1:0] shb_q, shb_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic             carry_q, carry_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic             cell_s;
   logic             cell_co;

   fa_cell u_fa_cell (
      .a  (sha_q[0]),
      .b  (shb_q[0]),
      .ci (carry_q),
      .s  (cell_s),
      .co (cell_co)
   );

   // Next-state, datapath update and output-register inputs.
   always_comb begin
      state_d = state_q;
      sha_d   = sha_q;
      shb_d   = shb_q;
      acc_d   = acc_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            // A start in DONE is accepted just like IDLE for back-to-back use.
            if (start) begin
               sha_d   = a;
               shb_d   = sub ? ~b : b;
               carry_d = sub ? 1'b1 : cin;
               acc_d   = {WIDTH{1'b0}};
               cnt_d   = {CW{1'b0}};
               state_d = ST_RUN;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            sha_d   = {1'b0, sha_q[WIDTH-1:1]};
            shb_d   = {1'b0, shb_q[WIDTH-1:1]};
            acc_d   = {cell_s, acc_q[WIDTH-1:1]};
            carry_d = cell_co;
            cnt_d   = cnt_q + CNT_ONE;
            if (cnt_q == CNT_LAST) begin
               // MSB edge: carry_q is the carry into the MSB.
               sum_d   = {cell_s, acc_q[WIDTH-1:1]};
               cout_d  = cell_co;
               ovf_d   = carry_q ^ cell_co;
               cnt_d   = {CW{1'b0}};
               state_d = ST_DONE;
            end else begin
               state_d = ST_RUN;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d == ST_RUN);
      done_d = (state_d == ST_DONE);
   end

   // State, datapath and output registers; reset discards any partial operation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         sha_q   <= {WIDTH{1'b0}};
         shb_q   <= {WIDTH{1'b0}};
         acc_q   <= {WIDTH{1'b0}};
         carry_q <= 1'b0;
         cnt_q   <= {CW{1'b0}};
         sum_q   <= {WIDTH{1'b0}};
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sha_q   <= sha_d;
         shb_q   <= shb_d;
         acc_q   <= acc_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign sum  = sum_q;
   assign cout = cout_q;
   assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8): table-driven vectors,
// hand-written multi-cycle sequences, and a result scoreboard fed at each
// accepted start and drained on every done pulse.
`timescale 1ns/1ps
module tb_serial_add_ctrl;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic         sub;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;
   logic         ovf;

   typedef struct {
      logic         sub;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic [W-1:0] s;
      logic         co;
      logic         ov;
   } vec_t;

   typedef struct {
      logic [W-1:0] s;
      logic         co;
      logic         ov;
   } res_t;

   res_t exp_q[$];
   int   n_vec  = 0;
   int   n_fail = 0;
   int   n_done = 0;

   serial_add_ctrl #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .sub   (sub),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout),
      .ovf   (ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference arithmetic: whole-word add in WIDTH+1 bits.
   function automatic res_t model(input logic s, input logic [W-1:0] x,
                                  input logic [W-1:0] y, input logic c);
      logic [W:0]   t;
      logic [W-1:0] yy;
      res_t         r;
      yy   = s ? ~y : y;
      t    = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, (s ? 1'b1 : c)};
      r.s  = t[W-1:0];
      r.co = t[W];
      r.ov = (x[W-1] == yy[W-1]) && (r.s[W-1] != x[W-1]);
      return r;
   endfunction

   // Scoreboard: every done pulse must match the oldest pending result.
   always @(negedge clk) begin
      if (done === 1'b1) begin
         n_done++;
         check("done_has_pending", (exp_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
         if (exp_q.size() > 0) begin
            res_t r;
            r = exp_q.pop_front();
            check("sum", sum, r.s);
            check("cout", cout, r.co);
            check("ovf", ovf, r.ov);
         end
      end
   end

   task automatic push_exp(input logic [W-1:0] s, input logic co, input logic ov);
      res_t r;
      r.s = s; r.co = co; r.ov = ov;
      exp_q.push_back(r);
   endtask

   // Issue one operation from an idle DUT and check its timing; called at a negedge.
   task automatic run_vec(input vec_t v);
      start = 1'b1; sub = v.sub; a = v.a; b = v.b; cin = v.cin;
      push_exp(v.s, v.co, v.ov);
      @(negedge clk);
      start = 1'b0;
      a = W'($urandom); b = W'($urandom); sub = 1'($urandom); cin = 1'($urandom);
      check("busy_after_start", busy, 1);
      check("no_done_at_start", done, 0);
      for (int i = 1; i <= W; i++) begin
         @(negedge clk);
         if (i == W - 1) check("done_not_early", done, 0);
         if (i == W) begin
            check("done_latency", done, 1);
            check("busy_in_done", busy, 0);
         end
      end
      @(negedge clk);
      check("done_one_cycle", done, 0);
      check("sum_held", sum, v.s);
   endtask

   vec_t tbl[10];

   initial begin
      int   d0;
      vec_t v;
      res_t r;

      tbl[0] = '{1'b0, 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1};
      tbl[1] = '{1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
      tbl[2] = '{1'b0, 8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1};
      tbl[3] = '{1'b1, 8'h10, 8'h01, 1'b1, 8'h0F, 1'b1, 1'b0};
      tbl[4] = '{1'b1, 8'h01, 8'h02, 1'b0, 8'hFF, 1'b0, 1'b0};
      tbl[5] = '{1'b1, 8'h10, 8'h01, 1'b0, 8'h0F, 1'b1, 1'b0};
      tbl[6] = '{1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
      tbl[7] = '{1'b0, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
      tbl[8] = '{1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1};
      tbl[9] = '{1'b0, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};

      rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0; cin = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_sum", sum, 0);
      check("rst_cout", cout, 0);
      check("rst_ovf", ovf, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Table vectors.
      for (int i = 0; i < 10; i++) begin
         run_vec(tbl[i]);
         @(negedge clk);
      end

      // Random vectors against the reference model.
      for (int i = 0; i < 6; i++) begin
         v.sub = 1'($urandom); v.a = W'($urandom); v.b = W'($urandom); v.cin = 1'($urandom);
         r = model(v.sub, v.a, v.b, v.cin);
         v.s = r.s; v.co = r.co; v.ov = r.ov;
         run_vec(v);
      end

      // start during RUN is ignored: one done, first operands' result.
      d0 = n_done;
      start = 1'b1; sub = 1'b0; a = 8'h5A; b = 8'h3C; cin = 1'b0;
      push_exp(8'h96, 1'b0, 1'b1);
      @(negedge clk);
      start = 1'b0;
      for (int i = 1; i <= W + 1; i++) begin
         if (i == 3) begin
            start = 1'b1; a = 8'h11; b = 8'h22; sub = 1'b1; cin = 1'b1;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         if (i == W) check("ign_done_latency", done, 1);
         if (i == W + 1) check("ign_done_one_cycle", done, 0);
      end
      start = 1'b0;
      repeat (W + 3) @(negedge clk);
      check("ign_single_done", n_done - d0, 1);

      // Reset in the middle of an operation.
      start = 1'b1; sub = 1'b0; a = 8'h7F; b = 8'h00; cin = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      exp_q.delete();
      check("mid_rst_busy", busy, 0);
      check("mid_rst_done", done, 0);
      check("mid_rst_sum", sum, 0);
      check("mid_rst_ovf", ovf, 0);
      @(negedge clk);
      rst_n = 1'b1;
      d0 = n_done;
      repeat (W + 3) @(negedge clk);
      check("no_stray_done", n_done - d0, 0);
      run_vec(tbl[3]);
      @(negedge clk);

      // start held high with changing operands: accepted every W+1 edges.
      d0 = n_done;
      for (int k = 0; k < 4 * (W + 1); k++) begin
         start = 1'b1;
         sub = 1'($urandom); a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
         if (k % (W + 1) == 0) begin
            r = model(sub, a, b, cin);
            exp_q.push_back(r);
         end
         @(negedge clk);
      end
      start = 1'b0;
      repeat (W + 4) @(negedge clk);
      check("b2b_done_count", n_done - d0, 4);

      check("scoreboard_empty", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
